// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller that sits in front of a single-port,
// synchronous-read RAM (2**ADDR_W x DATA_W). Reads and writes share the one
// RAM port; a pending read wins the port in IDLE, and the following RD_WAIT
// cycle leaves the port free for a write. The show-ahead output register
// holds the oldest word.
// Build option: define FIFO_BYPASS_EN so that a write arriving while the RAM
// and the output register are both empty loads the output register directly.
module ram_fifo_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W:0]     ram_cnt;

    logic pop;
    logic out_free;
    logic need_rd;
    logic issue_rd;
    logic not_full;
    logic wr_fire;
    logic ram_wr;
    logic byp;

    // Port arbitration, handshakes and the RAM-side drive
    always_comb begin
        pop      = rd_valid & rd_ready;
        out_free = !rd_valid | rd_ready;
        need_rd  = (ram_cnt != '0) & out_free;
        issue_rd = (state == IDLE) & need_rd;
        not_full = (count < FULL_CNT);
        // No write is accepted while reset is held, so ram_we stays low then.
        wr_ready = !rst & !issue_rd & not_full;
        wr_fire  = wr_valid & wr_ready;
`ifdef FIFO_BYPASS_EN
        byp      = wr_fire & (state == IDLE) & (ram_cnt == '0) & out_free;
`else
        byp      = 1'b0;
`endif
        ram_wr   = wr_fire & !byp;
        ram_we   = ram_wr;
        ram_din  = wr_data;
        ram_addr = '0;
        if (issue_rd) begin
            ram_addr = rd_ptr;
        end else if (ram_wr) begin
            ram_addr = wr_ptr;
        end
    end

    // Arbitration FSM plus RAM pointers and RAM-resident word count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
        end else begin
            state <= issue_rd ? RD_WAIT : IDLE;
            if (ram_wr) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (issue_rd) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            ram_cnt <= ram_cnt + {{ADDR_W{1'b0}}, ram_wr} - {{ADDR_W{1'b0}}, issue_rd};
        end
    end

    // Show-ahead output register: filled from the RAM in RD_WAIT, or by bypass
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (state == RD_WAIT) begin
            rd_valid <= 1'b1;
            rd_data  <= ram_dout;
        end else if (byp) begin
            rd_valid <= 1'b1;
            rd_data  <= wr_data;
        end else if (pop) begin
            rd_valid <= 1'b0;
        end
    end

    // Total occupancy, including a word in flight between RAM and output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count + {{ADDR_W{1'b0}}, wr_fire} - {{ADDR_W{1'b0}}, pop};
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl with a behavioural 1024x8 synchronous-read RAM
// and a queue-based reference model of FIFO contents.
module tb_ram_fifo_ctrl;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  wr_data = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [7:0]  rd_data;
    logic [10:0] count;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;

    logic [7:0]  mem [DEPTH];

    int tests = 0;
    int fails = 0;
    int pushes = 0;
    int pops = 0;
    bit prev_ok = 1'b1;
    logic [7:0] q [$];

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .count    (count),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    // Single-port RAM with one-cycle read latency
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample mid-cycle and apply the rules that hold in every cycle
    task automatic at_neg();
        @(negedge clk);
        check("count", 32'(count), 32'(q.size()));
        if (q.size() == 0) check("empty_rd_valid", 32'(rd_valid), 32'd0);
        if (q.size() == DEPTH) check("full_wr_ready", 32'(wr_ready), 32'd0);
        if (!wr_ready && q.size() < DEPTH) begin
            check("stall_alternates", 32'(prev_ok), 32'd1);
            check("stall_no_ram_we", 32'(ram_we), 32'd0);
        end
        if (rd_valid && rd_ready && q.size() != 0)
            check("pop_data", 32'(rd_data), 32'(q[0]));
    endtask

    // Update the model with this cycle's handshakes, then cross the edge
    task automatic commit();
        prev_ok = wr_ready | (q.size() == DEPTH);
        if (rd_valid && rd_ready && q.size() != 0) begin
            void'(q.pop_front());
            pops++;
        end
        if (wr_valid && wr_ready) begin
            q.push_back(wr_data);
            pushes++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        at_neg();
        commit();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        while (q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        check("drain_done", 32'(q.size()), 32'd0);
        repeat (3) cycle();
    endtask

    // Assert reset mid-cycle for two cycles; called at posedge+1
    task automatic pulse_reset();
        wr_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        q.delete();
        prev_ok = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_wr_ready", 32'(wr_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int base;
        int p0;

        // 1: reset
        @(posedge clk);
        #1;
        pulse_reset();

        // 2: single word latency
        rd_ready = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h56;
        at_neg();
        check("t2_wr_ready_N", 32'(wr_ready), 32'd1);
`ifdef FIFO_BYPASS_EN
        check("t2_we_N", 32'(ram_we), 32'd0);
`else
        check("t2_we_N", 32'(ram_we), 32'd1);
        check("t2_addr_N", 32'(ram_addr), 32'd0);
        check("t2_din_N", 32'(ram_din), 32'h56);
`endif
        commit();
        wr_valid = 1'b0;
`ifdef FIFO_BYPASS_EN
        at_neg();
        check("t2_valid_N1", 32'(rd_valid), 32'd1);
        check("t2_data_N1", 32'(rd_data), 32'h56);
        check("t2_count_N1", 32'(count), 32'd1);
        commit();
`else
        at_neg();
        check("t2_we_N1", 32'(ram_we), 32'd0);
        check("t2_addr_N1", 32'(ram_addr), 32'd0);
        check("t2_valid_N1", 32'(rd_valid), 32'd0);
        commit();
        at_neg();
        check("t2_valid_N2", 32'(rd_valid), 32'd0);
        commit();
        at_neg();
        check("t2_valid_N3", 32'(rd_valid), 32'd1);
        check("t2_data_N3", 32'(rd_data), 32'h56);
        check("t2_count_N3", 32'(count), 32'd1);
        commit();
`endif
        at_neg();
        check("t2_count_after_pop", 32'(count), 32'd0);
        check("t2_valid_after_pop", 32'(rd_valid), 32'd0);
        commit();

        // 3: fill to 1024, reject extra write, drain in order
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        k = 0;
        while (q.size() < DEPTH && k < 3000) begin
            wr_data = 8'(q.size());
            cycle();
            k++;
        end
        wr_data = 8'hFF;
        at_neg();
        check("t3_count_full", 32'(count), 32'd1024);
        check("t3_wr_ready_full", 32'(wr_ready), 32'd0);
        check("t3_no_ram_we_full", 32'(ram_we), 32'd0);
        commit();
        repeat (3) cycle();
        p0 = pops;
        drain(5000);
        check("t3_drained_words", 32'(pops - p0), 32'd1024);

        // 4: wrap with random interleaving, occupancy 0..20
        base = pushes;
        p0 = pops;
        k = 0;
        while (pushes - base < 1500 && k < 20000) begin
            wr_valid = (q.size() < 20) && ($urandom_range(0, 3) != 0);
            wr_data  = 8'(pushes - base);
            rd_ready = 1'($urandom_range(0, 1));
            cycle();
            k++;
        end
        check("t4_pushes", 32'(pushes - base), 32'd1500);
        drain(200);
        check("t4_pops", 32'(pops - p0), 32'd1500);

        // 5: contention with 10 words preloaded
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        k = 0;
        while (q.size() < 10 && k < 50) begin
            wr_data = 8'($urandom);
            cycle();
            k++;
        end
        check("t5_preload", 32'(q.size()), 32'd10);
        p0 = pops;
        base = pushes;
        rd_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            wr_data = 8'($urandom);
            cycle();
        end
        check("t5_pop_rate", 32'((pops - p0) >= 80), 32'd1);
        check("t5_push_rate", 32'((pushes - base) >= 80), 32'd1);
        drain(200);

        // 6: reset with data stored and output valid
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        k = 0;
        while (q.size() < 5 && k < 50) begin
            wr_data = 8'($urandom);
            cycle();
            k++;
        end
        wr_valid = 1'b0;
        k = 0;
        while (!rd_valid && k < 10) begin
            cycle();
            k++;
        end
        check("t6_rd_valid_before", 32'(rd_valid), 32'd1);
        check("t6_count_before", 32'(count), 32'd5);
        pulse_reset();
        p0 = pops;
        wr_valid = 1'b1;
        wr_data  = 8'h36;
        rd_ready = 1'b1;
        k = 0;
        while (q.size() == 0 && k < 10) begin
            cycle();
            k++;
        end
        wr_valid = 1'b0;
        k = 0;
        while (!rd_valid && k < 10) begin
            at_neg();
            commit();
            k++;
        end
        at_neg();
        check("t6_readback", 32'(rd_data), 32'h36);
        commit();
        drain(20);
        check("t6_single_word", 32'(pops - p0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
